// File: rtl/serial_mac_if.sv
// Operand-load, control and byte-readout signals of serial_mac_unit.
// master = stimulus side, slave = the MAC unit.
interface serial_mac_if #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 1
);
    logic [DATA_W-1:0] din;
    logic              valid;
    logic              acc_en;
    logic              clr;
    logic [SEL_W-1:0]  byte_sel;
    logic [7:0]        dout;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [1:0]        dbg_state;

    // valid is a raw, asynchronous push-button level. It is not a valid/ready
    // pair: there is no ready. A digit is taken on the debounced rising
    // edge only while the unit is idle. Presses while busy are silently dropped.
    modport master (
        output din, valid, acc_en, clr, byte_sel,
        input  dout, busy, done, ovf, dbg_state
    );
    modport slave (
        input  din, valid, acc_en, clr, byte_sel,
        output dout, busy, done, ovf, dbg_state
    );
endinterface

// File: rtl/serial_mac_unit.sv
// Digit-loaded shift-add multiplier with debounced load button, optional
// accumulation into a 2*OP_W result and byte-wise readout.
module serial_mac_unit #(
    parameter int DATA_W    = 4,
    parameter int OP_W      = 8,
    parameter int DB_CYCLES = 256
) (
    input logic          clk,
    input logic          reset,
    serial_mac_if.slave  bus
);
    localparam int RES_W = 2 * OP_W;
    localparam int NT    = RES_W / DATA_W;
    localparam int NB    = RES_W / 8;
    localparam int SEL_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int NC_W  = (NT > 1) ? $clog2(NT) : 1;
    localparam int IT_W  = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam int CNT_W = $clog2(DB_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic               sync1, sync2, db, db_q;
    logic [CNT_W-1:0]   cnt;
    logic               ld;
    logic [RES_W-1:0]   opr;
    logic [NC_W-1:0]    nc;
    logic [IT_W-1:0]    it;
    logic [RES_W-1:0]   pp;
    logic [RES_W-1:0]   result;
    logic               ovf_r;
    logic               done_r;
    logic [OP_W-1:0]    op_a, op_b;
    logic [RES_W:0]     sum;
    logic [7:0]         dout_c;

    // Debouncer is deliberately outside clr so an abort cannot fake a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= bus.valid;
            sync2 <= sync1;
            db_q  <= db;
            if (sync2 != db) begin
                if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign ld   = db & ~db_q;
    assign op_a = opr[RES_W-1:OP_W];
    assign op_b = opr[OP_W-1:0];
    assign sum  = {1'b0, result} + {1'b0, pp};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (ld && nc == NC_W'(NT - 1)) state_nx = S_MUL;
            S_MUL:   if (it == IT_W'(OP_W - 1))     state_nx = S_WB;
            S_WB:    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (bus.clr) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opr    <= '0;
            nc     <= '0;
            it     <= '0;
            pp     <= '0;
            result <= '0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.clr) begin
            opr    <= '0;
            nc     <= '0;
            it     <= '0;
            pp     <= '0;
            result <= '0;
            ovf_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ld) begin
                        opr <= {opr[RES_W-DATA_W-1:0], bus.din};
                        if (nc == NC_W'(NT - 1)) begin
                            nc <= '0;
                            it <= '0;
                            pp <= '0;
                        end else begin
                            nc <= nc + NC_W'(1);
                        end
                    end
                end
                S_MUL: begin
                    // One multiplier bit per clock, LSB first.
                    if (op_b[it]) pp <= pp + ({{OP_W{1'b0}}, op_a} << it);
                    it <= it + IT_W'(1);
                end
                S_WB: begin
                    if (bus.acc_en) begin
                        result <= sum[RES_W-1:0];
                        ovf_r  <= ovf_r | sum[RES_W];
                    end else begin
                        result <= pp;
                        ovf_r  <= 1'b0;
                    end
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Out-of-range selects read as zero.
    always_comb begin
        dout_c = '0;
        for (int i = 0; i < NB; i++) begin
            if (bus.byte_sel == SEL_W'(i)) dout_c = result[8*i +: 8];
        end
    end

    assign bus.dout      = dout_c;
    assign bus.busy      = (state == S_MUL) || (state == S_WB);
    assign bus.done      = done_r;
    assign bus.ovf       = ovf_r;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_serial_mac_unit.sv
// Self-checking bench for serial_mac_unit with OP_W=8, DATA_W=4, DB_CYCLES=4.
module tb_serial_mac_unit;
  localparam int DATA_W = 4;
  localparam int OP_W   = 8;
  localparam int DB     = 4;
  localparam int SEL_W  = 1;
  localparam int W      = 2 * OP_W + 1;

  logic clk;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [W-1:0]      exp_q[$];
  logic [2*OP_W-1:0] model_res = '0;
  logic              model_ovf = 1'b0;

  serial_mac_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) m_if ();

  serial_mac_unit #(.DATA_W(DATA_W), .OP_W(OP_W), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (m_if.done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic push_expected(input logic [7:0] a, input logic [7:0] b, input logic acc);
    logic [2*OP_W:0] s;
    if (acc) begin
      s = {1'b0, model_res} + {1'b0, 16'(a) * 16'(b)};
      model_res = s[2*OP_W-1:0];
      model_ovf = model_ovf | s[2*OP_W];
    end else begin
      model_res = 16'(a) * 16'(b);
      model_ovf = 1'b0;
    end
    exp_q.push_back({model_ovf, model_res});
  endtask

  task automatic press(input logic [3:0] d);
    @(negedge clk);
    m_if.din = d;
    m_if.valid = 1'b1;
    repeat (8) @(negedge clk);
    m_if.valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // scoreboard consumer: waits for done, pops and compares
  task automatic sb_wait(input string name);
    logic [W-1:0] e;
    bit got;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_if.done === 1'b1) begin
        got = 1;
        break;
      end
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_done: got done=0 for 40 cycles, expected done=1", name);
    end else begin
      exp_done++;
      m_if.byte_sel = 1'b0;
      #1;
      n_checks++;
      if (m_if.dout !== e[7:0]) begin
        n_fail++;
        $display("FAIL %s_byte0: got %h expected %h", name, m_if.dout, e[7:0]);
      end
      m_if.byte_sel = 1'b1;
      #1;
      n_checks++;
      if (m_if.dout !== e[15:8]) begin
        n_fail++;
        $display("FAIL %s_byte1: got %h expected %h", name, m_if.dout, e[15:8]);
      end
      n_checks++;
      if (m_if.ovf !== e[16]) begin
        n_fail++;
        $display("FAIL %s_ovf: got %b expected %b", name, m_if.ovf, e[16]);
      end
    end
  endtask

  task automatic load_op(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input logic acc, input string name);
    m_if.acc_en = acc;
    push_expected({d0, d1}, {d2, d3}, acc);
    press(d0);
    press(d1);
    press(d2);
    @(negedge clk);
    m_if.din = d3;
    m_if.valid = 1'b1;
    sb_wait(name);
    m_if.valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0 || m_if.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/ovf=%b%b%b expected 000", m_if.busy, m_if.done, m_if.ovf);
    end
    for (int s = 0; s < 2; s++) begin
      m_if.byte_sel = SEL_W'(s);
      #1;
      n_checks++;
      if (m_if.dout !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_dout%0d: got %h expected 00", s, m_if.dout);
      end
    end
    n_checks++;
    if (m_if.dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", m_if.dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    m_if.acc_en = 1'b0;
    push_expected(8'h34, 8'h05, 1'b0);
    press(4'h3);
    press(4'h4);
    press(4'h0);
    @(negedge clk);
    m_if.din = 4'h5;
    m_if.valid = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_early: got %b expected 0", m_if.busy);
    end
    @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_at_capture: got %b expected 1", m_if.busy);
    end
    for (int k = 8; k <= 15; k++) begin
      @(negedge clk);
      n_checks++;
      if (m_if.done !== 1'b0 || m_if.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_mul_window%0d: got done/busy=%b%b expected 01", k, m_if.done, m_if.busy);
      end
    end
    sb_wait("basic");
    n_checks++;
    if (m_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_fall: got %b expected 0", m_if.busy);
    end
    @(negedge clk);
    n_checks++;
    if (m_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %b expected 0", m_if.done);
    end
    m_if.valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_accumulate;
    load_op(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, "acc1");
    load_op(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, "acc2");
    load_op(4'h0, 4'h1, 4'h0, 4'h1, 1'b0, "acc_overwrite");
  endtask

  task automatic test_debounce;
    // 3-clock press must be filtered out entirely
    @(negedge clk);
    m_if.din = 4'h9;
    m_if.valid = 1'b1;
    repeat (3) @(negedge clk);
    m_if.valid = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0) begin
      n_fail++;
      $display("FAIL db_short: got busy/done=%b%b expected 00", m_if.busy, m_if.done);
    end
    // long hold with a one-clock dropout: one digit only
    m_if.acc_en = 1'b0;
    push_expected(8'h72, 8'h63, 1'b0);
    @(negedge clk);
    m_if.din = 4'h7;
    m_if.valid = 1'b1;
    repeat (8) @(negedge clk);
    m_if.valid = 1'b0;
    @(negedge clk);
    m_if.valid = 1'b1;
    repeat (5) @(negedge clk);
    m_if.valid = 1'b0;
    repeat (8) @(negedge clk);
    press(4'h2);
    press(4'h6);
    @(negedge clk);
    m_if.din = 4'h3;
    m_if.valid = 1'b1;
    sb_wait("db_glitch");
    m_if.valid = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_busy_drop;
    m_if.acc_en = 1'b0;
    push_expected(8'hA6, 8'h3B, 1'b0);
    press(4'hA);
    press(4'h6);
    press(4'h3);
    @(negedge clk);
    m_if.din = 4'hB;
    m_if.valid = 1'b1;
    repeat (4) @(negedge clk);
    m_if.valid = 1'b0;
    repeat (4) @(negedge clk);
    m_if.din = 4'hF;
    m_if.valid = 1'b1;
    sb_wait("busy_drop");
    m_if.valid = 1'b0;
    repeat (10) @(negedge clk);
    load_op(4'h1, 4'h2, 4'h0, 4'h3, 1'b0, "after_drop");
  endtask

  task automatic test_clr_abort;
    m_if.acc_en = 1'b0;
    press(4'h2);
    press(4'h2);
    press(4'h2);
    @(negedge clk);
    m_if.din = 4'h2;
    m_if.valid = 1'b1;
    repeat (9) @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre_busy: got %b expected 1", m_if.busy);
    end
    m_if.clr = 1'b1;
    @(negedge clk);
    m_if.clr = 1'b0;
    model_res = '0;
    model_ovf = 1'b0;
    n_checks++;
    if (m_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_busy: got %b expected 0", m_if.busy);
    end
    for (int s = 0; s < 2; s++) begin
      m_if.byte_sel = SEL_W'(s);
      #1;
      n_checks++;
      if (m_if.dout !== 8'h00) begin
        n_fail++;
        $display("FAIL clr_dout%0d: got %h expected 00", s, m_if.dout);
      end
    end
    m_if.valid = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== exp_done) begin
      n_fail++;
      $display("FAIL clr_no_done: got %0d done pulses expected %0d", done_cnt, exp_done);
    end
  endtask

  task automatic test_reset_abort;
    load_op(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, "pre_rst1");
    load_op(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, "pre_rst2");
    m_if.acc_en = 1'b1;
    press(4'h1);
    press(4'h1);
    press(4'h1);
    @(negedge clk);
    m_if.din = 4'h1;
    m_if.valid = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (m_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_busy: got %b expected 1", m_if.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    m_if.valid = 1'b0;
    #1;
    n_checks++;
    if (m_if.busy !== 1'b0 || m_if.done !== 1'b0 || m_if.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got busy/done/ovf=%b%b%b expected 000", m_if.busy, m_if.done, m_if.ovf);
    end
    for (int s = 0; s < 2; s++) begin
      m_if.byte_sel = SEL_W'(s);
      #1;
      n_checks++;
      if (m_if.dout !== 8'h00) begin
        n_fail++;
        $display("FAIL rst_dout%0d: got %h expected 00", s, m_if.dout);
      end
    end
    model_res = '0;
    model_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt !== exp_done || m_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d done pulses busy=%b expected %0d busy=0", done_cnt, m_if.busy, exp_done);
    end
    load_op(4'hC, 4'h8, 4'h0, 4'h9, 1'b0, "after_rst");
  endtask

  initial begin
    reset = 1'b0;
    m_if.din = '0;
    m_if.valid = 1'b0;
    m_if.acc_en = 1'b0;
    m_if.clr = 1'b0;
    m_if.byte_sel = '0;
    test_reset();
    test_basic();
    test_accumulate();
    test_debounce();
    test_busy_drop();
    test_clr_abort();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
